// File: rtl/alu_if.sv
// ============================================================================
// Module : typepkg / alu_if
// Brief  : ALU opcode package and the operand/result bundle used at the ALU port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package typepkg;
    typedef enum logic [3:0] {
        ALU_OP_ADD    = 4'd0,
        ALU_OP_SUB    = 4'd1,
        ALU_OP_AND    = 4'd2,
        ALU_OP_OR     = 4'd3,
        ALU_OP_XOR    = 4'd4,
        ALU_OP_SLL    = 4'd5,
        ALU_OP_SRL    = 4'd6,
        ALU_OP_SRA    = 4'd7,
        ALU_OP_SLT    = 4'd8,
        ALU_OP_SLTU   = 4'd9,
        ALU_OP_COPY_A = 4'd10
    } alu_op_t;

    // Recognisable marker driven on the result for any undefined opcode.
    localparam logic [31:0] BAD_VAL = 32'hDEAD_BEEF;
endpackage

interface alu_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]  operand_a;
    logic [XLEN-1:0]  operand_b;
    typepkg::alu_op_t alu_op;
    logic [XLEN-1:0]  result;
    logic             alu_zero;
    logic             alu_less;
    logic             alu_uless;
    logic [XLEN-1:0]  result_q;
    logic [2:0]       flags_q;
    logic             bad_op;
    logic             bad_op_sticky;

    modport master (
        output operand_a, operand_b, alu_op,
        input  result, alu_zero, alu_less, alu_uless,
        input  result_q, flags_q, bad_op, bad_op_sticky
    );

    modport slave (
        input  operand_a, operand_b, alu_op,
        output result, alu_zero, alu_less, alu_uless,
        output result_q, flags_q, bad_op, bad_op_sticky
    );
endinterface

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module : alu
// Brief  : 32-bit execute-stage ALU with compare flags, registered copies and
//          a sticky illegal-opcode indicator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu #(
    parameter int XLEN = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_if.slave      bus
);
    import typepkg::*;

    logic [XLEN-1:0] result;
    logic            bad_op;
    logic            alu_less;
    logic            alu_uless;
    logic            alu_zero;
    logic [4:0]      shamt;

    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] result_q;
    logic [2:0]      flags_d;
    logic [2:0]      flags_q;
    logic            sticky_d;
    logic            sticky_q;

    assign shamt     = bus.operand_b[4:0];
    assign alu_less  = $signed(bus.operand_a) < $signed(bus.operand_b);
    assign alu_uless = bus.operand_a < bus.operand_b;
    assign alu_zero  = (result == '0);

    always_comb begin
        result = '0;
        bad_op = 1'b0;
        case (bus.alu_op)
            ALU_OP_ADD:    result = bus.operand_a + bus.operand_b;
            ALU_OP_SUB:    result = bus.operand_a - bus.operand_b;
            ALU_OP_AND:    result = bus.operand_a & bus.operand_b;
            ALU_OP_OR:     result = bus.operand_a | bus.operand_b;
            ALU_OP_XOR:    result = bus.operand_a ^ bus.operand_b;
            ALU_OP_SLL:    result = bus.operand_a << shamt;
            ALU_OP_SRL:    result = bus.operand_a >> shamt;
            ALU_OP_SRA:    result = $signed(bus.operand_a) >>> shamt;
            ALU_OP_SLT:    result = {{(XLEN-1){1'b0}}, alu_less};
            ALU_OP_SLTU:   result = {{(XLEN-1){1'b0}}, alu_uless};
            ALU_OP_COPY_A: result = bus.operand_a;
            default: begin
                result = BAD_VAL;
                bad_op = 1'b1;
            end
        endcase
    end

    always_comb begin
        result_d = result;
        flags_d  = {alu_zero, alu_less, alu_uless};
        sticky_d = sticky_q | bad_op;
    end

    // Reset wins over a bad opcode presented on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= 3'b000;
            sticky_q <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.result        = result;
    assign bus.alu_zero      = alu_zero;
    assign bus.alu_less      = alu_less;
    assign bus.alu_uless     = alu_uless;
    assign bus.bad_op        = bad_op;
    assign bus.result_q      = result_q;
    assign bus.flags_q       = flags_q;
    assign bus.bad_op_sticky = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module : tb_alu
// Brief  : Directed-vector bench for alu with a queue-based scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu;
    import typepkg::*;

    typedef struct {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rst;
        logic [31:0] res;
        logic        less;
        logic        uless;
        logic        bad;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    vec_t vecs[$];
    vec_t exp_q[$];

    alu_if #(.XLEN(32)) bus ();

    alu #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic rst, input logic [31:0] res,
                           input logic less, input logic uless, input logic bad);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.rst = rst;
        v.res = res; v.less = less; v.uless = uless; v.bad = bad;
        vecs.push_back(v);
    endtask

    // Monitor: comb outputs checked against the popped entry; registered
    // outputs checked one cycle later against the previous entry.
    initial begin : monitor
        vec_t cur;
        vec_t last;
        bit   last_valid;
        logic sticky_exp;
        last_valid = 1'b0;
        sticky_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (last_valid) begin
                if (last.rst) begin
                    sticky_exp = 1'b0;
                    chk("result_q", bus.result_q, 32'h0);
                    chk("flags_q", {29'b0, bus.flags_q}, 32'h0);
                end else begin
                    sticky_exp = sticky_exp | last.bad;
                    chk("result_q", bus.result_q, last.res);
                    chk("flags_q", {29'b0, bus.flags_q},
                        {29'b0, (last.res == 32'h0), last.less, last.uless});
                end
                chk("bad_op_sticky", {31'b0, bus.bad_op_sticky}, {31'b0, sticky_exp});
                last_valid = 1'b0;
            end
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk("result", bus.result, cur.res);
                chk("alu_zero", {31'b0, bus.alu_zero}, {31'b0, (cur.res == 32'h0)});
                chk("alu_less", {31'b0, bus.alu_less}, {31'b0, cur.less});
                chk("alu_uless", {31'b0, bus.alu_uless}, {31'b0, cur.uless});
                chk("bad_op", {31'b0, bus.bad_op}, {31'b0, cur.bad});
                last       = cur;
                last_valid = 1'b1;
            end
        end
    end

    initial begin : stim
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.alu_op    = ALU_OP_ADD;

        //      op                    a             b             rst   result        lt   ult  bad
        add_vec(ALU_OP_ADD,           32'h1,        32'h2,        1'b1, 32'h3,        1'b1, 1'b1, 1'b0);
        add_vec(ALU_OP_ADD,           32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
        add_vec(ALU_OP_ADD,           32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
        add_vec(ALU_OP_ADD,           32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b1, 1'b0);
        add_vec(ALU_OP_SUB,           32'h0,        32'h1,        1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        add_vec(ALU_OP_SUB,           32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
        add_vec(ALU_OP_SUB,           32'h3,        32'h1,        1'b0, 32'h2,        1'b0, 1'b0, 1'b0);
        add_vec(ALU_OP_AND,           32'hFFFF0000, 32'h0000FFFF, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
        add_vec(ALU_OP_OR,            32'hFFFF0000, 32'h0000FFFF, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        add_vec(ALU_OP_XOR,           32'hFFFF0000, 32'h0000FFFF, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        add_vec(ALU_OP_SLL,           32'h80000000, 32'h1,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
        add_vec(ALU_OP_SRL,           32'hFFFFFFFF, 32'h1,        1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
        add_vec(ALU_OP_SRA,           32'h80000000, 32'h1,        1'b0, 32'hC0000000, 1'b1, 1'b0, 1'b0);
        add_vec(ALU_OP_SRA,           32'hFFFF1000, 32'h2,        1'b0, 32'hFFFFC400, 1'b1, 1'b0, 1'b0);
        add_vec(ALU_OP_SLL,           32'h1,        32'h21,       1'b0, 32'h2,        1'b1, 1'b1, 1'b0);
        add_vec(ALU_OP_SRL,           32'h80000000, 32'hFFFFFFE1, 1'b0, 32'h40000000, 1'b1, 1'b1, 1'b0);
        add_vec(ALU_OP_SLT,           32'h1,        32'h2,        1'b0, 32'h1,        1'b1, 1'b1, 1'b0);
        add_vec(ALU_OP_SLTU,          32'h1,        32'h2,        1'b0, 32'h1,        1'b1, 1'b1, 1'b0);
        add_vec(ALU_OP_SLT,           32'h2,        32'h1,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
        add_vec(ALU_OP_SLTU,          32'h2,        32'h1,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
        add_vec(ALU_OP_SLT,           32'hFFFFFFFF, 32'h1,        1'b0, 32'h1,        1'b1, 1'b0, 1'b0);
        add_vec(ALU_OP_SLTU,          32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
        add_vec(ALU_OP_COPY_A,        32'hFFFFFFFF, 32'h5,        1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        add_vec(alu_op_t'(4'b1111),   32'h5,        32'h5,        1'b0, BAD_VAL,      1'b0, 1'b0, 1'b1);
        add_vec(ALU_OP_COPY_A,        32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
        add_vec(ALU_OP_ADD,           32'h1,        32'h1,        1'b0, 32'h2,        1'b0, 1'b0, 1'b0);
        add_vec(alu_op_t'(4'b1011),   32'h7,        32'h3,        1'b1, BAD_VAL,      1'b0, 1'b0, 1'b1);
        add_vec(ALU_OP_ADD,           32'h7,        32'h3,        1'b0, 32'hA,        1'b0, 1'b0, 1'b0);
        add_vec(alu_op_t'(4'b1100),   32'hFFFFFFFF, 32'h0,        1'b0, BAD_VAL,      1'b1, 1'b0, 1'b1);
        add_vec(ALU_OP_COPY_A,        32'h55,       32'h0,        1'b0, 32'h55,       1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            bus.operand_a = vecs[i].a;
            bus.operand_b = vecs[i].b;
            bus.alu_op    = vecs[i].op;
            rst_n         = ~vecs[i].rst;
            exp_q.push_back(vecs[i]);
        end

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
